// File: rtl/sar_seq.sv
// sar_seq: SAR ADC conversion sequencer (sample, per-bit compare/latch, result handshake)
module sar_seq #(
  parameter int NBIT       = 9,
  parameter int SAMPLE_CYC = 4
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            START,
  input  logic            CMP_P,
  input  logic            CMP_N,
  input  logic            DREADY,
  output logic            CKSB,
  output logic            CKC,
  output logic [NBIT-1:0] CF,
  output logic [NBIT-1:0] DOUT,
  output logic            DVALID,
  output logic            BUSY,
  output logic            OVR,
  output logic            ERR
);
  localparam int KW = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam int CW = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
  typedef enum logic [2:0] {IDLE, SAMPLE, CONV_A, CONV_B, CONV_C} state_t;
  state_t state, state_d;
  logic [KW-1:0] k, k_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [NBIT-1:0] sr, sr_d, cf_d, dout_d;
  logic cksb_d, ckc_d, dvalid_d, busy_d, ovr_d, err_d, resolved;
  assign resolved = CMP_P ^ CMP_N;
  // State and every output are registered so the analog-facing clocks stay glitch-free
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= IDLE;
      k      <= '0;
      cnt    <= '0;
      sr     <= '0;
      CKSB   <= 1'b0;
      CKC    <= 1'b0;
      CF     <= '0;
      DOUT   <= '0;
      DVALID <= 1'b0;
      BUSY   <= 1'b0;
      OVR    <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state  <= state_d;
      k      <= k_d;
      cnt    <= cnt_d;
      sr     <= sr_d;
      CKSB   <= cksb_d;
      CKC    <= ckc_d;
      CF     <= cf_d;
      DOUT   <= dout_d;
      DVALID <= dvalid_d;
      BUSY   <= busy_d;
      OVR    <= ovr_d;
      ERR    <= err_d;
    end
  end
  // Next state and next output values; CF defaults low so it is only ever one-hot in phase B
  always_comb begin
    state_d  = state;
    k_d      = k;
    cnt_d    = cnt;
    sr_d     = sr;
    cksb_d   = CKSB;
    ckc_d    = CKC;
    cf_d     = '0;
    dout_d   = DOUT;
    dvalid_d = DVALID & ~DREADY;
    busy_d   = BUSY;
    ovr_d    = OVR;
    err_d    = ERR;
    case (state)
      IDLE: if (START) begin
        state_d = SAMPLE;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
      SAMPLE: if (cnt == CW'(SAMPLE_CYC - 1)) begin
        state_d = CONV_A;
        k_d     = KW'(NBIT - 1);
        cksb_d  = 1'b1;
        ckc_d   = 1'b1;
      end else begin
        cnt_d = cnt + CW'(1);
      end
      CONV_A: begin
        state_d = CONV_B;
        cf_d    = NBIT'(1) << k;
        sr_d[k] = resolved & CMP_P;
        err_d   = ERR | ~resolved;
      end
      CONV_B: begin
        state_d = CONV_C;
        ckc_d   = 1'b0;
      end
      CONV_C: if (k == '0) begin
        dout_d   = sr;
        dvalid_d = 1'b1;
        ovr_d    = OVR | (DVALID & ~DREADY);
        cksb_d   = 1'b0;
        busy_d   = START;
        cnt_d    = '0;
        state_d  = START ? SAMPLE : IDLE;
      end else begin
        k_d     = k - KW'(1);
        ckc_d   = 1'b1;
        state_d = CONV_A;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sar_seq.sv
// tb_sar_seq: self-checking bench for sar_seq with a comparator model and timing reference
module tb_sar_seq;
  localparam int N  = 9;
  localparam int SC = 4;
  logic CLK = 1'b0, RSTN, START, CMP_P, CMP_N, DREADY;
  logic CKSB, CKC, DVALID, BUSY, OVR, ERR;
  logic [N-1:0] CF, DOUT;
  logic [N-1:0] pat_p = '0, pat_n = '0;
  int checks = 0, errors = 0, bi = N - 1;

  sar_seq #(.NBIT(N), .SAMPLE_CYC(SC)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .CMP_P(CMP_P), .CMP_N(CMP_N), .DREADY(DREADY),
    .CKSB(CKSB), .CKC(CKC), .CF(CF), .DOUT(DOUT), .DVALID(DVALID), .BUSY(BUSY),
    .OVR(OVR), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // Comparator model: presents the pattern bit only while evaluating (CKC=1, no strobe), junk otherwise
  always @(negedge CLK) begin
    if (!CKSB) bi = N - 1;
    else if (CF != '0) bi = bi - 1;
    if (CKSB && CKC && CF == '0 && bi >= 0) begin
      CMP_P = pat_p[bi];
      CMP_N = pat_n[bi];
    end else begin
      CMP_P = 1'($urandom);
      CMP_N = 1'($urandom);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {BUSY,CKSB,CKC,DVALID,CF} in cycle n+t of an isolated conversion started at edge n
  function automatic logic [12:0] exp_tl(input int t);
    int p = t - SC - 1;
    logic [N-1:0] cf = '0;
    logic ckc = 1'b0;
    if (p >= 0 && p < 3 * N) begin
      ckc = (p % 3) != 2;
      if (p % 3 == 1) cf = N'(1) << (N - 1 - p / 3);
    end
    return {t <= SC + 3 * N, t > SC && t <= SC + 3 * N, ckc, t == SC + 3 * N + 1, cf};
  endfunction

  task automatic run_conv(input logic [N-1:0] cp, cn, edout, input logic eerr);
    pat_p = cp;
    pat_n = cn;
    START = 1'b1;
    for (int t = 1; t <= SC + 3 * N + 1; t++) begin
      @(negedge CLK);
      START = 1'b0;
      chk("timing", {BUSY, CKSB, CKC, DVALID, CF}, exp_tl(t));
      if (t == 1) chk("err_clear", ERR, 0);
    end
    chk("dout", DOUT, edout);
    chk("err", ERR, eerr);
    chk("ovr", OVR, 0);
  endtask

  task automatic accept();
    DREADY = 1'b1;
    @(negedge CLK);
    DREADY = 1'b0;
    chk("accept", DVALID, 0);
  endtask

  typedef struct {logic [N-1:0] cp, cn, dout; logic err;} vec_t;
  vec_t vt[7];

  initial begin
    logic [N-1:0] cp, cn;
    int code;
    logic e, found, stable;
    vt[0] = '{9'h155, 9'h0AA, 9'h155, 1'b0};
    vt[1] = '{9'h0AA, 9'h155, 9'h0AA, 1'b0};
    vt[2] = '{9'h1EF, 9'h000, 9'h1EF, 1'b1};
    vt[3] = '{9'h1FF, 9'h001, 9'h1FE, 1'b1};
    vt[4] = '{9'h000, 9'h1FF, 9'h000, 1'b0};
    vt[5] = '{9'h1FF, 9'h000, 9'h1FF, 1'b0};
    vt[6] = '{9'h100, 9'h100, 9'h000, 1'b1};
    RSTN = 1'b0;
    START = 1'b1;
    DREADY = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      START = 1'($urandom);
      DREADY = 1'($urandom);
      chk("reset_outs", {CKSB, CKC, CF, DOUT, DVALID, BUSY, OVR, ERR}, 0);
    end
    START = 1'b0;
    DREADY = 1'b0;
    RSTN = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk("idle_quiet", {CKSB, CKC, CF, DVALID, BUSY}, 0);
    end
    foreach (vt[i]) begin
      run_conv(vt[i].cp, vt[i].cn, vt[i].dout, vt[i].err);
      accept();
    end
    run_conv(9'h155, 9'h0AA, 9'h155, 1'b0);
    stable = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      stable &= DVALID && DOUT == 9'h155;
    end
    chk("hs_hold", stable, 1);
    accept();
    chk("hs_ovr", OVR, 0);
    for (int i = 0; i < 8; i++) begin
      cp = N'($urandom);
      cn = ~cp;
      if ($urandom_range(0, 2) == 0) begin
        int r = $urandom_range(0, N - 1);
        cn[r] = cp[r];
      end
      code = 0;
      e = 1'b0;
      for (int b = 0; b < N; b++) begin
        if (cp[b] != cn[b]) code += cp[b] ? (1 << b) : 0;
        else e = 1'b1;
      end
      run_conv(cp, cn, N'(code), e);
      accept();
    end
    pat_p = 9'h0AA;
    pat_n = ~pat_p;
    START = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge CLK);
      found = DVALID;
    end
    chk("fr_first_done", found, 1);
    chk("fr_first_dout", DOUT, 9'h0AA);
    chk("fr_first_ovr", OVR, 0);
    pat_p = 9'h1F0;
    pat_n = ~pat_p;
    repeat (30) @(negedge CLK);
    chk("fr_hold_first", DOUT, 9'h0AA);
    @(negedge CLK);
    chk("fr_second_dout", DOUT, 9'h1F0);
    chk("fr_second_ovr", {OVR, DVALID, BUSY}, 3'b111);
    START = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge CLK);
      found = !BUSY;
    end
    chk("fr_stop", found, 1);
    chk("ovr_sticky", OVR, 1);
    pat_p = 9'h155;
    pat_n = ~pat_p;
    START = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK);
      START = 1'b0;
      found = CF == 9'h020;
    end
    chk("bit5_reached", found, 1);
    RSTN = 1'b0;
    #1;
    chk("async_rst", {CF, CKC, CKSB, BUSY, OVR}, 0);
    @(negedge CLK);
    RSTN = 1'b1;
    run_conv(9'h0F3, 9'h10C, 9'h0F3, 1'b0);
    accept();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sar_seq.md
# sar_seq

Synchronous SAR conversion sequencer for the 9-bit SAR ADC. It drives the sampling clock `CKSB`, the comparator clock `CKC`, and the one-hot per-bit latch strobes `CF[8:0]` that the CDAC switch controller consumes. It captures each comparator decision into a result register and presents the finished code on a valid/ready output port.

## Interface
- `NBIT`, 9: resolution; width of `CF` and `DOUT`.
- `SAMPLE_CYC`, 4: minimum track cycles after `START` is accepted (≥1).
- `CLK`  in  1  system clock; all logic on rising edge.
- `RSTN`  in  1  reset. Asynchronous, active-low.
- `START`  in  1  conversion request, level-sensitive.
- `CMP_P`  in  1  comparator positive decision; valid while `CKC`=1, after one `CLK` period.
- `CMP_N`  in  1  comparator negative decision; complement of `CMP_P` when resolved.
- `DREADY`  in  1  downstream accepts `DOUT`.
- `CKSB`  out  1  sample clock: 0 = track (clears CDAC switches), 1 = hold/convert.
- `CKC`  out  1  comparator clock: 1 = evaluate, 0 = reset.
- `CF`  out  NBIT  one-hot bit-latch strobes; CDAC switches latch on rising edge.
- `DOUT`  out  NBIT  conversion result, MSB = bit NBIT-1.
- `DVALID`  out  1  `DOUT` holds an unconsumed result.
- `BUSY`  out  1  conversion in progress (SAMPLE or CONV).
- `OVR`  out  1  sticky: a result overwrote an unconsumed one.
- `ERR`  out  1  sticky: a comparator decision was unresolved or invalid.

## Operation
- States: IDLE, SAMPLE, CONV. CONV has a bit index `k` (NBIT-1 down to 0) and a phase (A, B, C).
- Reset values: `CKSB`=0, `CKC`=0, `CF`=0, `DOUT`=0, `DVALID`=0, `BUSY`=0, `OVR`=0, `ERR`=0, state IDLE.
- All outputs are registered and glitch-free. `CF` is never more than one-hot.
- IDLE: `CKSB`=0 (tracking). If `START`=1, go to SAMPLE and clear `ERR`.
- SAMPLE: `CKSB`=0, `BUSY`=1. Lasts exactly `SAMPLE_CYC` cycles, then enters CONV with k=NBIT-1, phase A.
- CONV: `CKSB`=1, `BUSY`=1.
  - Phase A: `CKC`=1, `CF`=0.
  - Phase B: `CKC`=1, `CF[k]`=1.
  - Phase C: `CKC`=0, `CF`=0 (comparator reset and DAC settle).
- Decision capture happens on the A→B edge, the same edge on which `CF[k]` rises:
  - `CMP_P`≠`CMP_N`: result bit k = `CMP_P`.
  - `CMP_P`=`CMP_N`: result bit k = 0 and `ERR` is set.
- After bit 0 phase C:
  - `DOUT` ← shift register.
  - `DVALID` ← 1.
  - If `DVALID` was 1 and `DREADY` was 0 on that edge, set `OVR`. New data overwrites the old.
  - Next state is SAMPLE if `START`=1 (free-running), otherwise IDLE. `CKSB` returns to 0.
- Handshake:
  - `DVALID` and `DOUT` are held stable until a cycle with `DVALID`=1 and `DREADY`=1; `DVALID` clears on that edge.
  - Completion on the same edge as an accept leaves `DVALID`=1 with the new data and does not set `OVR`.
- `OVR` clears only on reset. `ERR` clears at the next accepted `START`.
- `START` is ignored while `BUSY`=1.
- `RSTN` low at any point, including mid-conversion, forces all reset values immediately. `CKSB`=0 clears the CDAC switches.

## Timing
- Let edge n sample `START`=1 in IDLE.
- `BUSY` rises after edge n. SAMPLE occupies cycles n+1 … n+`SAMPLE_CYC`.
- `CKSB` rises after edge n+`SAMPLE_CYC`.
- Bit k phase A is cycle n+`SAMPLE_CYC`+1+3·(NBIT-1-k). Phases B and C follow in the next two cycles.
- `CF[k]` is high for exactly 1 cycle, every 3 cycles, MSB first.
- `DVALID` rises after edge n+`SAMPLE_CYC`+3·NBIT. With the defaults this is n+31, first visible in cycle n+32.
- In the same cycle `BUSY` drops (IDLE) or stays 1 (free-run). `CKSB` falls at that point.
- Free-run throughput: one result every `SAMPLE_CYC`+3·NBIT = 31 cycles.
- Comparator timing constraint: `CMP_P`/`CMP_N` must be settled within one `CLK` period of `CKC` rising. There is no synchronizer.

## Test plan
- Reset: hold `RSTN`=0 with random inputs → all outputs 0, `CKSB`=0. Release → IDLE with no activity until `START`.
- Single conversion: `START` pulsed 1 cycle; comparator model returns bit pattern 1_0101_0101. Required:
  - `CF` sequence 0x100, 0x080, … 0x001, each 1 cycle high, 3 cycles apart.
  - `DOUT`=0x155 with `DVALID`=1, 32 cycles after the `START` edge.
  - `BUSY` then 0.
- Handshake: hold `DREADY`=0 for 10 cycles after `DVALID` → `DOUT` and `DVALID` stay stable. Raise `DREADY` → `DVALID`=0 on the next cycle. `OVR` stays 0.
- Free-run overrun: `START` held 1, `DREADY`=0, codes 0x0AA then 0x1F0 → `OVR`=1 at the second completion, with `DOUT`=0x1F0. Completions are 31 cycles apart.
- Unresolved comparator: `CMP_P`=`CMP_N`=0 at bit 4 capture, all other bits 1 → `DOUT`=0x1EF and `ERR`=1. `ERR` clears on the next accepted `START`.
- Reset mid-conversion: assert `RSTN`=0 during bit 5 phase B → `CF`, `CKC`, `CKSB`, and `BUSY` go to 0 without waiting for a clock. A subsequent `START` completes a normal conversion.
